// File: rtl/ixc_clock_scheduler.sv
// rtl/ixc_clock_scheduler.sv - event scheduler for emulated clock generators
// Offers the smallest time-to-next-edge as a delta and toggles expiring clocks on commit.
module ixc_clock_scheduler #(
  parameter int NUM_CLK = 4,
  parameter int HPW     = 10,
  parameter int DW      = 11,
  parameter int TW      = 32,
  localparam int IW     = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
  input  logic               eclk,
  input  logic               rstn,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_idx,
  input  logic [HPW-1:0]     cfg_half_period,
  input  logic [NUM_CLK-1:0] cfg_enable,
  output logic               cfg_err,
  input  logic               run,
  output logic               adv_valid,
  input  logic               adv_ack,
  output logic [DW-1:0]      delta,
  output logic [NUM_CLK-1:0] phi,
  output logic [TW-1:0]      sim_time,
  output logic               sim_time_wrap
);

  localparam int SW = ((TW > DW) ? TW : DW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OFFER, S_COMMIT} state_t;

  state_t             state_q, state_d;
  logic [HPW-1:0]     hp_q [NUM_CLK];
  logic [HPW-1:0]     hp_d [NUM_CLK];
  logic [HPW-1:0]     cd_q [NUM_CLK];
  logic [HPW-1:0]     cd_d [NUM_CLK];
  logic [NUM_CLK-1:0] en_q, en_d;
  logic [NUM_CLK-1:0] phi_q, phi_d;
  logic [IW-1:0]      scan_idx_q, scan_idx_d;
  logic [HPW-1:0]     min_q, min_d;
  logic [DW-1:0]      delta_q, delta_d;
  logic [TW-1:0]      sim_time_q, sim_time_d;
  logic               wrap_q, wrap_d;
  logic               cfg_err_q, cfg_err_d;
  logic [HPW-1:0]     cand, pick;
  logic [SW-1:0]      sum_wide;

  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    cd_d       = cd_q;
    en_d       = en_q;
    phi_d      = phi_q;
    scan_idx_d = scan_idx_q;
    min_d      = min_q;
    delta_d    = delta_q;
    sim_time_d = sim_time_q;
    wrap_d     = 1'b0;
    cfg_err_d  = cfg_we && (state_q != S_IDLE);
    cand       = (scan_idx_q == '0) ? '1 : min_q;
    pick       = cand;
    // Wide add so the carry out of TW bits is visible even when DW > TW.
    sum_wide   = SW'(sim_time_q) + SW'(delta_q);

    case (state_q)
      S_IDLE: begin
        en_d = cfg_enable;
        if (cfg_we && (int'(cfg_idx) < NUM_CLK)) begin
          hp_d[cfg_idx] = (cfg_half_period == '0) ? HPW'(1) : cfg_half_period;
        end
        if (run && (|cfg_enable)) begin
          for (int i = 0; i < NUM_CLK; i++) begin
            if (cfg_enable[i]) cd_d[i] = hp_q[i];
          end
          scan_idx_d = '0;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (en_q[scan_idx_q] && (cd_q[scan_idx_q] < cand)) pick = cd_q[scan_idx_q];
        min_d = pick;
        if (scan_idx_q == IW'(NUM_CLK - 1)) begin
          delta_d = DW'(pick);
          state_d = S_OFFER;
        end else begin
          scan_idx_d = scan_idx_q + IW'(1);
        end
      end
      S_OFFER: begin
        if (adv_ack) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        for (int i = 0; i < NUM_CLK; i++) begin
          if (en_q[i]) begin
            if (cd_q[i] == delta_q[HPW-1:0]) begin
              phi_d[i] = ~phi_q[i];
              cd_d[i]  = hp_q[i];
            end else begin
              cd_d[i] = cd_q[i] - delta_q[HPW-1:0];
            end
          end
        end
        sim_time_d = sum_wide[TW-1:0];
        wrap_d     = |sum_wide[SW-1:TW];
        scan_idx_d = '0;
        state_d    = run ? S_SCAN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge eclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < NUM_CLK; i++) begin
        hp_q[i] <= HPW'(1);
        cd_q[i] <= '0;
      end
      en_q       <= '0;
      phi_q      <= '0;
      scan_idx_q <= '0;
      min_q      <= '0;
      delta_q    <= '0;
      sim_time_q <= '0;
      wrap_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      cd_q       <= cd_d;
      en_q       <= en_d;
      phi_q      <= phi_d;
      scan_idx_q <= scan_idx_d;
      min_q      <= min_d;
      delta_q    <= delta_d;
      sim_time_q <= sim_time_d;
      wrap_q     <= wrap_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign adv_valid     = (state_q == S_OFFER);
  assign delta         = delta_q;
  assign phi           = phi_q;
  assign sim_time      = sim_time_q;
  assign sim_time_wrap = wrap_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_ixc_clock_scheduler.sv
// tb/tb_ixc_clock_scheduler.sv - directed self-checking bench for ixc_clock_scheduler
// Narrow sim_time (TW=4) so the wrap case is reachable with short runs.
module tb_ixc_clock_scheduler;

  logic        eclk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [9:0]  cfg_half_period = '0;
  logic [3:0]  cfg_enable = '0;
  logic        cfg_err;
  logic        run = 1'b0;
  logic        adv_valid;
  logic        adv_ack = 1'b0;
  logic [10:0] delta;
  logic [3:0]  phi;
  logic [3:0]  sim_time;
  logic        sim_time_wrap;

  int tests_run = 0;
  int tests_failed = 0;

  ixc_clock_scheduler #(.NUM_CLK(4), .HPW(10), .DW(11), .TW(4)) dut (
    .eclk(eclk), .rstn(rstn), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_half_period(cfg_half_period), .cfg_enable(cfg_enable), .cfg_err(cfg_err),
    .run(run), .adv_valid(adv_valid), .adv_ack(adv_ack), .delta(delta),
    .phi(phi), .sim_time(sim_time), .sim_time_wrap(sim_time_wrap)
  );

  always #5 eclk = ~eclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; run = 1'b0; adv_ack = 1'b0; cfg_we = 1'b0; cfg_enable = '0;
    repeat (2) @(negedge eclk);
    rstn = 1'b1;
    @(negedge eclk);
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [9:0] hp);
    cfg_we = 1'b1; cfg_idx = idx; cfg_half_period = hp;
    @(negedge eclk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_offer();
    int n = 0;
    while (!adv_valid && n < 40) begin
      @(negedge eclk);
      n++;
    end
    if (!adv_valid) check("offer_timeout", 32'(adv_valid), 32'd1);
  endtask

  task automatic take_offer(input int exp_delta, input int exp_time,
                            input logic [3:0] exp_phi, input logic exp_wrap);
    wait_offer();
    check("delta", 32'(delta), 32'(exp_delta));
    adv_ack = 1'b1;
    @(negedge eclk);
    adv_ack = 1'b0;
    check("valid_in_commit", 32'(adv_valid), 32'd0);
    @(negedge eclk);
    check("sim_time", 32'(sim_time), 32'(exp_time));
    check("phi", 32'(phi), 32'(exp_phi));
    check("wrap", 32'(sim_time_wrap), 32'(exp_wrap));
  endtask

  initial begin
    @(negedge eclk);
    check("rst_phi", 32'(phi), 32'd0);
    check("rst_valid", 32'(adv_valid), 32'd0);
    check("rst_delta", 32'(delta), 32'd0);
    check("rst_time", 32'(sim_time), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_wrap", 32'(sim_time_wrap), 32'd0);

    // Run with nothing enabled must not leave IDLE.
    do_reset();
    run = 1'b1;
    repeat (8) @(negedge eclk);
    check("no_enable_idle", 32'(adv_valid), 32'd0);

    // hp0=3, hp1=5 with a held offer and a dropped config write.
    do_reset();
    cfg_write(2'd0, 10'd3);
    cfg_write(2'd1, 10'd5);
    cfg_enable = 4'b0011;
    run = 1'b1;
    wait_offer();
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(adv_valid), 32'd1);
      check("hold_delta", 32'(delta), 32'd3);
      @(negedge eclk);
    end
    cfg_write(2'd1, 10'd7);
    check("cfg_err_pulse", 32'(cfg_err), 32'd1);
    @(negedge eclk);
    check("cfg_err_clear", 32'(cfg_err), 32'd0);
    take_offer(3, 3, 4'b0001, 1'b0);
    take_offer(2, 5, 4'b0011, 1'b0);
    take_offer(1, 6, 4'b0010, 1'b0);
    take_offer(3, 9, 4'b0011, 1'b0);
    take_offer(1, 10, 4'b0001, 1'b0);

    // Equal half-periods toggle together; run drop returns to IDLE holding state.
    do_reset();
    cfg_write(2'd0, 10'd4);
    cfg_write(2'd1, 10'd4);
    cfg_enable = 4'b0011;
    run = 1'b1;
    take_offer(4, 4, 4'b0011, 1'b0);
    take_offer(4, 8, 4'b0000, 1'b0);
    wait_offer();
    run = 1'b0;
    take_offer(4, 12, 4'b0011, 1'b0);
    repeat (8) @(negedge eclk);
    check("idle_valid", 32'(adv_valid), 32'd0);
    check("idle_time", 32'(sim_time), 32'd12);
    check("idle_phi", 32'(phi), 32'b0011);

    // Half-period 0 is stored as 1.
    do_reset();
    cfg_write(2'd0, 10'd0);
    cfg_enable = 4'b0001;
    run = 1'b1;
    take_offer(1, 1, 4'b0001, 1'b0);
    take_offer(1, 2, 4'b0000, 1'b0);
    take_offer(1, 3, 4'b0001, 1'b0);

    // sim_time wraps modulo 16, then asynchronous reset mid-offer.
    do_reset();
    cfg_write(2'd0, 10'd5);
    cfg_enable = 4'b0001;
    run = 1'b1;
    take_offer(5, 5, 4'b0001, 1'b0);
    take_offer(5, 10, 4'b0000, 1'b0);
    take_offer(5, 15, 4'b0001, 1'b0);
    take_offer(5, 4, 4'b0000, 1'b1);
    @(negedge eclk);
    check("wrap_one_cycle", 32'(sim_time_wrap), 32'd0);
    take_offer(5, 9, 4'b0001, 1'b0);
    wait_offer();
    rstn = 1'b0;
    #1;
    check("async_valid", 32'(adv_valid), 32'd0);
    check("async_phi", 32'(phi), 32'd0);
    check("async_time", 32'(sim_time), 32'd0);
    check("async_delta", 32'(delta), 32'd0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
